// File: rtl/dipsw_debounce_pio.sv
// dipsw_debounce_pio
// Avalon-MM slave on the lightweight HPS-to-FPGA bridge that samples the
// board DIP switches, debounces every bit, and reports the stable value,
// an edge-capture register and a level interrupt to the HPS.
//
// Optional feature macro: DIPSW_PIO_EDGE_IRQ_EN
//   defined     : edge capture, IRQMASK (addr 2), EDGECAP (addr 3, W1C), irq
//   not defined : addresses 2/3 read 0 and ignore writes, irq tied low
//
// Ports
//   clk_clk        in   system clock
//   reset_reset    in   asynchronous, active-high reset
//   sw_in          in   raw switch pins (asynchronous to clk_clk)
//   avs_address    in   word address
//   avs_read       in   read strobe
//   avs_write      in   write strobe
//   avs_writedata  in   write data
//   avs_readdata   out  read data, valid one cycle after the read is sampled
//   irq            out  level interrupt, active high
//
// Register map: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (RW1C)

module dipsw_debounce_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [WIDTH-1:0]  sw_in,
   input  logic [1:0]        avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq
);

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] db_q, db_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [31:0]      readdata_q, readdata_d;
   logic [31:0]      rd_word;

`ifdef DIPSW_PIO_EDGE_IRQ_EN
   logic [WIDTH-1:0] db_dly_q, db_dly_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] w1c_clr;
   logic             irq_q, irq_d;
   logic             unused_wdata;

   // Only the low WIDTH bits of the write data carry register content.
   assign unused_wdata = ^avs_writedata;

   always_comb begin
      db_dly_d  = db_q;
      irqmask_d = irqmask_q;
      w1c_clr   = '0;
      if (avs_write && avs_address == 2'd2) irqmask_d = avs_writedata[WIDTH-1:0];
      if (avs_write && avs_address == 2'd3) w1c_clr   = avs_writedata[WIDTH-1:0];
      // New edges are OR-ed in after the clear so a same-cycle edge survives.
      edgecap_d = (edgecap_q & ~w1c_clr) | (db_q ^ db_dly_q);
      irq_d     = |(edgecap_q & irqmask_q);
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         db_dly_q  <= '0;
         irqmask_q <= '0;
         edgecap_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         db_dly_q  <= db_dly_d;
         irqmask_q <= irqmask_d;
         edgecap_q <= edgecap_d;
         irq_q     <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   logic unused_wr;

   // Without edge capture there is no writable register.
   assign unused_wr = ^{avs_write, avs_writedata};
   assign irq       = 1'b0;
`endif

   // Synchronizer, per-bit debounce counters and read mux.
   always_comb begin
      sync1_d = sw_in;
      s_d     = sync1_q;
      db_d    = db_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (s_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_TC) db_d[i]  = s_q[i];
            else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      rd_word = '0;
      case (avs_address)
         2'd0:    rd_word[WIDTH-1:0] = db_q;
`ifdef DIPSW_PIO_EDGE_IRQ_EN
         2'd2:    rd_word[WIDTH-1:0] = irqmask_q;
         2'd3:    rd_word[WIDTH-1:0] = edgecap_q;
`endif
         default: rd_word = '0;
      endcase
      // Read data holds until the next read strobe.
      readdata_d = avs_read ? rd_word : readdata_q;
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sync1_q    <= '0;
         s_q        <= '0;
         db_q       <= '0;
         readdata_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q    <= sync1_d;
         s_q        <= s_d;
         db_q       <= db_d;
         readdata_q <= readdata_d;
         cnt_q      <= cnt_d;
      end
   end

   assign avs_readdata = readdata_q;

endmodule
